// File: rtl/count_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_drain_pkg
// Description : Shared defaults, state encoding and state type for count_drain.
// Revision    : 1.0 - initial release
// ============================================================================
package count_drain_pkg;

   localparam int c_width_def  = 8;
   localparam int c_step_w_def = 3;

   localparam int         c_state_w = 2;
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_run  = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   typedef enum logic [c_state_w-1:0] {
      ST_IDLE = c_st_idle,
      ST_RUN  = c_st_run,
      ST_DONE = c_st_done
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cg_cell.sv
`default_nettype none
// ============================================================================
// Module      : cg_cell
// Description : Latch-based integrated clock gate; enable is captured while
//               clk is low so gclk never glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module cg_cell (
   input  logic clk,
   input  logic gate_en,
   output logic gclk
);

   logic r_en_lat;

   always_latch begin
      if (!clk) begin
         r_en_lat <= gate_en;
      end
   end

   assign gclk = clk & r_en_lat;

endmodule
`default_nettype wire

// File: rtl/count_drain.sv
`default_nettype none
// ============================================================================
// Module      : count_drain
// Description : Loadable down-counter that drains by a per-cycle step, with a
//               saturating final step, done/underflow pulses and a gated count
//               register.
// Revision    : 1.0 - initial release
// ============================================================================
module count_drain
   import count_drain_pkg::*;
#(
   parameter int WIDTH  = c_width_def,
   parameter int STEP_W = c_step_w_def
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load_valid,
   input  logic [WIDTH-1:0]  load_data,
   output logic              load_ready,
   input  logic [STEP_W-1:0] decrease,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              underflow,
   output logic              gate_en
);

   // Comparisons run in a width wide enough for both operands.
   localparam int c_cw = (WIDTH > STEP_W) ? WIDTH : STEP_W;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             r_done;
   logic             r_underflow;
   logic             w_gate_en;
   logic             w_gclk;
   logic             w_dec_nz;
   logic             w_dec_ge;
   logic             w_dec_gt;
   logic [c_cw-1:0]  w_dec_w;
   logic [c_cw-1:0]  w_cnt_w;

   assign w_dec_w  = c_cw'(decrease);
   assign w_cnt_w  = c_cw'(r_count);
   assign w_dec_nz = |decrease;
   assign w_dec_ge = (w_dec_w >= w_cnt_w);
   assign w_dec_gt = (w_dec_w > w_cnt_w);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load_valid) begin
                  w_state_nxt = (load_data != '0) ? ST_RUN : ST_DONE;
               end
            end
            ST_RUN: begin
               if (w_dec_nz && w_dec_ge) begin
                  w_state_nxt = ST_DONE;
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM: output decode
   // ------------------------------------------------------------------
   always_comb begin
      load_ready = 1'b0;
      busy       = 1'b0;
      case (r_state)
         ST_IDLE: load_ready = 1'b1;
         ST_RUN:  busy       = 1'b1;
         default: begin
            load_ready = 1'b0;
            busy       = 1'b0;
         end
      endcase
   end

   // Pulses are registered on the ungated clock; clear suppresses both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_done      <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_done      <= !clear && (r_state == ST_DONE);
         r_underflow <= !clear && (r_state == ST_RUN) && w_dec_gt;
      end
   end

   assign done      = r_done;
   assign underflow = r_underflow;

   // ------------------------------------------------------------------
   // Gated count register
   // ------------------------------------------------------------------
   assign w_gate_en = ((r_state == ST_IDLE) && load_valid)
                    | ((r_state == ST_RUN) && w_dec_nz)
                    | clear;
   assign gate_en   = w_gate_en;

   // The subtraction is only taken when decrease < count, so the step fits WIDTH.
   always_comb begin
      w_count_nxt = r_count;
      if (clear) begin
         w_count_nxt = '0;
      end else if (r_state == ST_IDLE) begin
         w_count_nxt = load_data;
      end else if (w_dec_ge) begin
         w_count_nxt = '0;
      end else begin
         w_count_nxt = r_count - w_dec_w[WIDTH-1:0];
      end
   end

   cg_cell u_cg_cell (
      .clk     (clk),
      .gate_en (w_gate_en),
      .gclk    (w_gclk)
   );

   always_ff @(posedge w_gclk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign count = r_count;

endmodule
`default_nettype wire
